// File: rtl/fifo_pack_pkg.sv
// Shared definitions for the FIFO read-side packer: FSM states and the
// lane-enable mask helper.
package fifo_pack_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam int MAX_LANES = 32;

  // (1 << cnt) - 1, computed one bit wider so cnt == MAX_LANES still works
  function automatic logic [MAX_LANES-1:0] be_mask(input logic [7:0] cnt);
    logic [MAX_LANES:0] one;
    logic [MAX_LANES:0] mask;
    one  = (MAX_LANES+1)'(1);
    mask = (one << cnt) - one;
    return mask[MAX_LANES-1:0];
  endfunction

endpackage

// File: rtl/fifo_pack_acc.sv
// N-lane accumulator bank: one lane written per cycle, whole bank cleared
// together, and lanes at or above fill_cnt presented as zero.
module fifo_pack_acc #(
  parameter int DW = 8,
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [CW-1:0]   wr_idx,
  input  logic [DW-1:0]   wr_data,
  input  logic            lane_clr,
  input  logic [CW-1:0]   fill_cnt,
  output logic [DW*N-1:0] lanes
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [DW-1:0] lane_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          lane_reg <= '0;
        end else if (lane_clr) begin
          lane_reg <= '0;
        end else if (wr_en && (wr_idx == CW'(gi))) begin
          lane_reg <= wr_data;
        end
      end

      assign lanes[gi*DW +: DW] = (CW'(gi) < fill_cnt) ? lane_reg : '0;
    end
  endgenerate

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops entries from a single-clock FIFO (one cycle read latency), packs N of
// them little-endian into a word and offers it on a valid/ready stream.
module fifo_rd_packer
  import fifo_pack_pkg::*;
#(
  parameter  int DW = 8,
  parameter  int N  = 4,
  localparam int CW = $clog2(N+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fifo_empty,
  output logic            fifo_re,
  input  logic [DW-1:0]   fifo_dout,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW*N-1:0] out_data,
  output logic [N-1:0]    out_be,
  output logic            out_last,
  output logic            busy
);

  localparam logic [CW-1:0] N_CNT = CW'(N);
  localparam logic [CW:0]   N_SUM = (CW+1)'(N);

  state_t            state_reg, state_next;
  logic [CW-1:0]     acc_cnt_reg;
  logic              inflight_reg;
  logic              out_valid_reg;
  logic [DW*N-1:0]   out_data_reg;
  logic [N-1:0]      out_be_reg;
  logic              out_last_reg;

  logic              word_ready;
  logic              xfer;
  logic              fifo_re_next;
  logic [CW:0]       fill_sum;
  logic [DW*N-1:0]   acc_lanes;
  logic [MAX_LANES-1:0] be_full;

  fifo_pack_acc #(.DW(DW), .N(N), .CW(CW)) u_acc (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (inflight_reg),
    .wr_idx   (acc_cnt_reg),
    .wr_data  (fifo_dout),
    .lane_clr (xfer),
    .fill_cnt (acc_cnt_reg),
    .lanes    (acc_lanes)
  );

  // Issue a read only while the accumulator plus the entry in flight still
  // has room, or when a full word is leaving this very cycle.
  always_comb begin
    word_ready = 1'b0;
    if (state_reg == ST_RUN) begin
      word_ready = (acc_cnt_reg == N_CNT);
    end else begin
      word_ready = !inflight_reg && (acc_cnt_reg != '0);
    end
    xfer     = (!out_valid_reg || out_ready) && word_ready;
    fill_sum = {1'b0, acc_cnt_reg} + {{CW{1'b0}}, inflight_reg};
    fifo_re_next = !fifo_empty && (state_reg == ST_RUN) &&
                   ((fill_sum < N_SUM) || ((acc_cnt_reg == N_CNT) && xfer));
    be_full  = be_mask(8'(acc_cnt_reg));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (flush) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Leave once the last read has landed and any partial word has gone
        if (!inflight_reg && ((acc_cnt_reg == '0) || xfer)) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_RUN;
      acc_cnt_reg   <= '0;
      inflight_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_be_reg    <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= fifo_re_next;
      if (xfer) begin
        acc_cnt_reg <= '0;
      end else if (inflight_reg) begin
        acc_cnt_reg <= acc_cnt_reg + CW'(1);
      end
      if (xfer) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= acc_lanes;
        out_be_reg    <= be_full[N-1:0];
        out_last_reg  <= (state_reg == ST_FLUSH);
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign fifo_re   = fifo_re_next;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_be    = out_be_reg;
  assign out_last  = out_last_reg;
  assign busy      = (state_reg == ST_FLUSH);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a behavioural one-cycle-latency FIFO
// and a monitor that logs every accepted output word.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_empty;
  logic          fifo_re;
  logic [DW-1:0] fifo_dout = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic [3:0]    out_be;
  logic          out_last;
  logic          busy;

  int checks = 0;
  int errors = 0;

  fifo_rd_packer #(.DW(DW), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .fifo_dout  (fifo_dout),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_be     (out_be),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: pop on the edge that samples fifo_re, data valid next cycle
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_re) begin
      fifo_dout <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Monitor: per-cycle read log and accepted-word log
  int          ncyc = 0;
  int          nw = 0;
  int          re_cnt = 0;
  logic        re_hist [0:4095];
  logic [31:0] wd_data [0:63];
  logic [3:0]  wd_be [0:63];
  logic        wd_last [0:63];
  int          wd_cyc [0:63];

  always @(negedge clk) begin
    if (ncyc < 4096) re_hist[ncyc] = fifo_re;
    if (fifo_re) re_cnt++;
    if (rst && out_valid && out_ready && nw < 64) begin
      wd_data[nw] = out_data;
      wd_be[nw]   = out_be;
      wd_last[nw] = out_last;
      wd_cyc[nw]  = ncyc;
      $display("word %0d: data=%h be=%b last=%b cycle=%0d", nw, out_data, out_be, out_last, ncyc);
      nw++;
    end
    ncyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr++;
  endtask

  task automatic wait_words(input int target, input int budget);
    int k;
    k = 0;
    while (nw < target && k < budget) begin
      tick(1);
      k++;
    end
    if (nw < target) check("timeout_words", 32'(nw), 32'(target));
  endtask

  int base_re;
  int w0;
  int c0;
  logic [9:0] pat;

  initial begin
    // Reset state
    tick(3);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_re",    32'(fifo_re),   32'd0);
    check("rst_data",  out_data,       32'h0);
    check("rst_be",    32'(out_be),    32'h0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_last",  32'(out_last),  32'd0);
    rst = 1'b1;
    tick(2);

    // 1: single full word
    out_ready = 1'b1;
    base_re = re_cnt;
    w0 = nw;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_words(w0 + 1, 30);
    tick(3);
    check("t1_re_cnt", 32'(re_cnt - base_re), 32'd4);
    check("t1_data",   wd_data[w0],           32'h44332211);
    check("t1_be",     32'(wd_be[w0]),        32'hF);
    check("t1_last",   32'(wd_last[w0]),      32'd0);

    // 2: back-to-back words, one bubble per word
    base_re = re_cnt;
    w0 = nw;
    c0 = ncyc;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_words(w0 + 2, 40);
    tick(3);
    check("t2_data0", wd_data[w0],     32'h04030201);
    check("t2_data1", wd_data[w0 + 1], 32'h08070605);
    check("t2_gap",   32'(wd_cyc[w0 + 1] - wd_cyc[w0]), 32'd5);
    for (int i = 0; i < 10; i++) pat[9 - i] = re_hist[c0 + i];
    check("t2_re_pat", 32'(pat), 32'(10'b1111011110));
    check("t2_re_cnt", 32'(re_cnt - base_re), 32'd8);

    // 3: backpressure with 12 entries queued
    out_ready = 1'b0;
    base_re = re_cnt;
    w0 = nw;
    for (int i = 1; i <= 12; i++) push(8'(i));
    tick(20);
    check("t3_re_stall", 32'(re_cnt - base_re), 32'd8);
    check("t3_valid",    32'(out_valid),        32'd1);
    check("t3_data",     out_data,              32'h04030201);
    check("t3_no_acc",   32'(nw - w0),          32'd0);
    tick(3);
    check("t3_hold",     out_data,              32'h04030201);
    check("t3_re_hold",  32'(fifo_re),          32'd0);
    out_ready = 1'b1;
    wait_words(w0 + 3, 40);
    tick(3);
    check("t3_w0", wd_data[w0],     32'h04030201);
    check("t3_w1", wd_data[w0 + 1], 32'h08070605);
    check("t3_w2", wd_data[w0 + 2], 32'h0C0B0A09);
    check("t3_re_total", 32'(re_cnt - base_re), 32'd12);

    // 4: partial word closed by flush
    w0 = nw;
    push(8'hA1); push(8'hA2); push(8'hA3);
    tick(8);
    check("t4_no_partial", 32'(nw - w0),   32'd0);
    flush = 1'b1;
    check("t4_busy_pre",   32'(busy),      32'd0);
    tick(1);
    flush = 1'b0;
    check("t4_busy",       32'(busy),      32'd1);
    check("t4_valid_pre",  32'(out_valid), 32'd0);
    tick(1);
    check("t4_busy_fall",  32'(busy),      32'd0);
    check("t4_valid",      32'(out_valid), 32'd1);
    check("t4_data",       out_data,       32'h00A3A2A1);
    check("t4_be",         32'(out_be),    32'h7);
    check("t4_last",       32'(out_last),  32'd1);
    tick(2);
    check("t4_words",      32'(nw - w0),   32'd1);

    // 5a: flush with nothing accumulated
    w0 = nw;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("t5a_busy",      32'(busy),      32'd1);
    check("t5a_valid",     32'(out_valid), 32'd0);
    tick(1);
    check("t5a_busy_fall", 32'(busy),      32'd0);
    tick(5);
    check("t5a_words",     32'(nw - w0),   32'd0);

    // 5b: flush in the same cycle as the third read
    base_re = re_cnt;
    w0 = nw;
    push(8'hA1); push(8'hA2); push(8'hA3);
    tick(2);
    flush = 1'b1;
    check("t5b_re_at_flush", 32'(fifo_re), 32'd1);
    tick(1);
    flush = 1'b0;
    wait_words(w0 + 1, 20);
    tick(2);
    check("t5b_data",   wd_data[w0],          32'h00A3A2A1);
    check("t5b_be",     32'(wd_be[w0]),       32'h7);
    check("t5b_last",   32'(wd_last[w0]),     32'd1);
    check("t5b_re_cnt", 32'(re_cnt - base_re), 32'd3);

    // 5c: flush with a full accumulator behind a stalled output
    out_ready = 1'b0;
    w0 = nw;
    for (int i = 1; i <= 8; i++) push(8'(i));
    tick(15);
    check("t5c_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(3);
    check("t5c_busy_wait", 32'(busy), 32'd1);
    check("t5c_hold",      out_data,  32'h04030201);
    out_ready = 1'b1;
    wait_words(w0 + 2, 20);
    tick(2);
    check("t5c_w0",    wd_data[w0],            32'h04030201);
    check("t5c_last0", 32'(wd_last[w0]),       32'd0);
    check("t5c_w1",    wd_data[w0 + 1],        32'h08070605);
    check("t5c_be1",   32'(wd_be[w0 + 1]),     32'hF);
    check("t5c_last1", 32'(wd_last[w0 + 1]),   32'd1);
    check("t5c_busy",  32'(busy),              32'd0);

    // 6: asynchronous reset with a word pending and two lanes captured
    out_ready = 1'b0;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    tick(10);
    push(8'hE1); push(8'hE2);
    tick(6);
    check("t6_valid_pre", 32'(out_valid), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_data",  out_data,       32'h0);
    check("t6_be",    32'(out_be),    32'h0);
    check("t6_last",  32'(out_last),  32'd0);
    check("t6_busy",  32'(busy),      32'd0);
    check("t6_re",    32'(fifo_re),   32'd0);
    tick(2);
    rst = 1'b1;
    out_ready = 1'b1;
    w0 = nw;
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    wait_words(w0 + 1, 30);
    tick(2);
    check("t6_after_data", wd_data[w0],      32'h88776655);
    check("t6_after_be",   32'(wd_be[w0]),   32'hF);
    check("t6_after_last", 32'(wd_last[w0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
